// File: rtl/axi2mem_tcdm_wr_if.sv
// Write-side TCDM interface of axi2mem.
// Joins the write command stream and the write data stream into one TCDM write per beat.
// Two small FIFOs track the beats:
//   - the outstanding FIFO holds {id, last} for each beat issued to the TCDM;
//   - the completion FIFO holds the ids of finished bursts waiting for the B-channel.
// Issue is credit-limited: beats in flight plus queued completions never exceed
// OUTST_DEPTH, so the completion FIFO can never overflow.
module axi2mem_tcdm_wr_if #(
    parameter int unsigned OUTST_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trans_last_i,
    input  logic [5:0]  trans_id_i,
    input  logic [31:0] trans_add_i,
    input  logic        trans_req_i,
    output logic        trans_gnt_o,
    input  logic [31:0] data_dat_i,
    input  logic [3:0]  data_strb_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        synch_req_o,
    output logic [5:0]  synch_id_o,
    input  logic        synch_gnt_i,
    output logic        tcdm_req_o,
    output logic [31:0] tcdm_add_o,
    output logic        tcdm_we_o,
    output logic [31:0] tcdm_wdata_o,
    output logic [3:0]  tcdm_be_o,
    input  logic        tcdm_gnt_i,
    input  logic [31:0] tcdm_r_rdata_i,
    input  logic        tcdm_r_valid_i
);

    localparam int unsigned PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUTST_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(OUTST_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(OUTST_DEPTH);

    logic [5:0]    out_id_q   [OUTST_DEPTH];
    logic [5:0]    out_id_d   [OUTST_DEPTH];
    logic          out_last_q [OUTST_DEPTH];
    logic          out_last_d [OUTST_DEPTH];
    logic [PW-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [PW-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [CW-1:0] cnt_out_q, cnt_out_d;

    logic [5:0]    rsp_id_q   [OUTST_DEPTH];
    logic [5:0]    rsp_id_d   [OUTST_DEPTH];
    logic [PW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [PW-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [CW-1:0] cnt_rsp_q, cnt_rsp_d;

    logic can_issue;
    logic out_push, out_pop;
    logic rsp_push, rsp_pop;
    logic unused_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Handshakes, credit check and pass-through outputs; everything is gated off while in reset.
    always_comb begin
        can_issue    = ({1'b0, cnt_out_q} + {1'b0, cnt_rsp_q}) < DEPTH_C;
        tcdm_req_o   = ~rst_i & trans_req_i & data_req_i & can_issue;
        out_push     = tcdm_req_o & tcdm_gnt_i;
        trans_gnt_o  = out_push;
        data_gnt_o   = out_push;
        out_pop      = ~rst_i & tcdm_r_valid_i & (cnt_out_q != '0);
        rsp_push     = out_pop & out_last_q[out_rd_ptr_q];
        synch_req_o  = ~rst_i & (cnt_rsp_q != '0);
        synch_id_o   = synch_req_o ? rsp_id_q[rsp_rd_ptr_q] : 6'd0;
        rsp_pop      = synch_req_o & synch_gnt_i;
        tcdm_add_o   = trans_add_i;
        tcdm_wdata_o = data_dat_i;
        tcdm_be_o    = data_strb_i;
        tcdm_we_o    = 1'b0;
        unused_rdata = ^tcdm_r_rdata_i;
    end

    // Next state of the outstanding FIFO: push on grant, pop on each TCDM write completion.
    always_comb begin
        out_id_d     = out_id_q;
        out_last_d   = out_last_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        cnt_out_d    = cnt_out_q;
        if (out_push) begin
            out_id_d[out_wr_ptr_q]   = trans_id_i;
            out_last_d[out_wr_ptr_q] = trans_last_i;
            out_wr_ptr_d             = ptr_inc(out_wr_ptr_q);
        end
        if (out_pop) begin
            out_rd_ptr_d = ptr_inc(out_rd_ptr_q);
        end
        case ({out_push, out_pop})
            2'b10:   cnt_out_d = cnt_out_q + 1'b1;
            2'b01:   cnt_out_d = cnt_out_q - 1'b1;
            default: cnt_out_d = cnt_out_q;
        endcase
    end

    // Next state of the completion FIFO: push the id when a burst's last beat completes.
    always_comb begin
        rsp_id_d     = rsp_id_q;
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        cnt_rsp_d    = cnt_rsp_q;
        if (rsp_push) begin
            rsp_id_d[rsp_wr_ptr_q] = out_id_q[out_rd_ptr_q];
            rsp_wr_ptr_d           = ptr_inc(rsp_wr_ptr_q);
        end
        if (rsp_pop) begin
            rsp_rd_ptr_d = ptr_inc(rsp_rd_ptr_q);
        end
        case ({rsp_push, rsp_pop})
            2'b10:   cnt_rsp_d = cnt_rsp_q + 1'b1;
            2'b01:   cnt_rsp_d = cnt_rsp_q - 1'b1;
            default: cnt_rsp_d = cnt_rsp_q;
        endcase
    end

    // State registers; reset empties both FIFOs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(OUTST_DEPTH); i++) begin
                out_id_q[i]   <= '0;
                out_last_q[i] <= 1'b0;
                rsp_id_q[i]   <= '0;
            end
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            cnt_out_q    <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            cnt_rsp_q    <= '0;
        end else begin
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            cnt_out_q    <= cnt_out_d;
            rsp_id_q     <= rsp_id_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            cnt_rsp_q    <= cnt_rsp_d;
        end
    end

endmodule

// File: tb/tb_axi2mem_tcdm_wr_if.sv
// Bench for axi2mem_tcdm_wr_if: directed scenarios plus a randomized run against a queue-based model.
module tb_axi2mem_tcdm_wr_if;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        trans_last_i;
    logic [5:0]  trans_id_i;
    logic [31:0] trans_add_i;
    logic        trans_req_i;
    logic        trans_gnt_o;
    logic [31:0] data_dat_i;
    logic [3:0]  data_strb_i;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        synch_req_o;
    logic [5:0]  synch_id_o;
    logic        synch_gnt_i;
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_we_o;
    logic [31:0] tcdm_wdata_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_r_rdata_i;
    logic        tcdm_r_valid_i;

    always #5 clk = ~clk;

    axi2mem_tcdm_wr_if #(.OUTST_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .trans_last_i   (trans_last_i),
        .trans_id_i     (trans_id_i),
        .trans_add_i    (trans_add_i),
        .trans_req_i    (trans_req_i),
        .trans_gnt_o    (trans_gnt_o),
        .data_dat_i     (data_dat_i),
        .data_strb_i    (data_strb_i),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .synch_req_o    (synch_req_o),
        .synch_id_o     (synch_id_o),
        .synch_gnt_i    (synch_gnt_i),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_we_o      (tcdm_we_o),
        .tcdm_wdata_o   (tcdm_wdata_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_r_rdata_i (tcdm_r_rdata_i),
        .tcdm_r_valid_i (tcdm_r_valid_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats in flight and finished burst ids waiting for the B-channel.
    typedef struct packed {
        logic [5:0] id;
        logic       last;
    } beat_t;
    beat_t      out_q[$];
    logic [5:0] rsp_q[$];

    logic       exp_req, exp_gnt, exp_sreq;
    logic [5:0] exp_sid;
    logic       last_issue;

    // Credit invariant: beats in flight plus queued completions never exceed the pool.
    always @(negedge clk) begin
        checks++;
        if (int'(dut.cnt_out_q) + int'(dut.cnt_rsp_q) > DEPTH) begin
            errors++;
            $display("FAIL credit_overflow cnt_out %0d cnt_rsp %0d limit %0d", dut.cnt_out_q, dut.cnt_rsp_q, DEPTH);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        trans_req_i    = 1'b0;
        data_req_i     = 1'b0;
        trans_last_i   = 1'b0;
        trans_id_i     = '0;
        trans_add_i    = '0;
        data_dat_i     = '0;
        data_strb_i    = '0;
        tcdm_gnt_i     = 1'b0;
        tcdm_r_valid_i = 1'b0;
        synch_gnt_i    = 1'b0;
        tcdm_r_rdata_i = $urandom;
    endtask

    task automatic drive_beat(input logic [5:0] id, input logic [31:0] add, input logic [31:0] dat,
                              input logic [3:0] strb, input logic last);
        trans_id_i   = id;
        trans_add_i  = add;
        data_dat_i   = dat;
        data_strb_i  = strb;
        trans_last_i = last;
        trans_req_i  = 1'b1;
        data_req_i   = 1'b1;
    endtask

    // Move to the sampling point and derive this cycle's expected outputs from the model.
    task automatic settle();
        @(negedge clk);
        exp_req  = !rst_i && trans_req_i && data_req_i && (out_q.size() + rsp_q.size() < DEPTH);
        exp_gnt  = exp_req && tcdm_gnt_i;
        exp_sreq = !rst_i && (rsp_q.size() != 0);
        exp_sid  = exp_sreq ? rsp_q[0] : 6'd0;
    endtask

    // Apply this cycle's events to the model, then step past the clock edge.
    task automatic adv();
        logic  done, sync;
        beat_t b;
        last_issue = exp_gnt;
        if (rst_i) begin
            out_q.delete();
            rsp_q.delete();
        end else begin
            done = tcdm_r_valid_i && (out_q.size() != 0);
            sync = (rsp_q.size() != 0) && synch_gnt_i;
            if (sync) void'(rsp_q.pop_front());
            if (done) begin
                b = out_q.pop_front();
                if (b.last) rsp_q.push_back(b.id);
            end
            if (exp_gnt) begin
                b.id   = trans_id_i;
                b.last = trans_last_i;
                out_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        drive_beat(6'h11, 32'h4, 32'h1234, 4'hF, 1'b1);
        tcdm_gnt_i     = 1'b1;
        tcdm_r_valid_i = 1'b1;
        settle();
        checks++;
        if (tcdm_req_o !== 1'b0 || trans_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue got req %b tg %b dg %b want 0 0 0", tcdm_req_o, trans_gnt_o, data_gnt_o);
        end
        adv();
        idle();
        rst_i = 1'b0;
        settle();
        checks++;
        if (synch_req_o !== 1'b0 || synch_id_o !== 6'd0 || tcdm_we_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got sreq %b sid %h we %b req %b want 0 00 0 0", synch_req_o, synch_id_o, tcdm_we_o, tcdm_req_o);
        end
        checks++;
        if (dut.cnt_out_q !== '0 || dut.cnt_rsp_q !== '0) begin
            errors++;
            $display("FAIL reset_counts got %0d %0d want 0 0", dut.cnt_out_q, dut.cnt_rsp_q);
        end
        adv();
    endtask

    task automatic drain();
        idle();
        synch_gnt_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (out_q.size() == 0 && rsp_q.size() == 0) break;
            tcdm_r_valid_i = (out_q.size() != 0);
            settle();
            checks++;
            if (synch_req_o !== exp_sreq || synch_id_o !== exp_sid) begin
                errors++;
                $display("FAIL drain_synch got %b/%h want %b/%h", synch_req_o, synch_id_o, exp_sreq, exp_sid);
            end
            adv();
        end
        idle();
        checks++;
        if (out_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout model queues %0d %0d want 0 0", out_q.size(), rsp_q.size());
        end
    endtask

    task automatic test_single_beat();
        idle();
        drive_beat(6'h15, 32'h1000_0010, 32'hDEADBEEF, 4'hF, 1'b1);
        tcdm_gnt_i  = 1'b1;
        synch_gnt_i = 1'b1;
        settle();
        checks++;
        if (tcdm_req_o !== 1'b1 || tcdm_we_o !== 1'b0 || trans_gnt_o !== 1'b1 || data_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL single_issue got req %b we %b tg %b dg %b want 1 0 1 1", tcdm_req_o, tcdm_we_o, trans_gnt_o, data_gnt_o);
        end
        checks++;
        if (tcdm_add_o !== 32'h1000_0010 || tcdm_wdata_o !== 32'hDEADBEEF || tcdm_be_o !== 4'hF) begin
            errors++;
            $display("FAIL single_passthru got %h %h %h want 10000010 deadbeef f", tcdm_add_o, tcdm_wdata_o, tcdm_be_o);
        end
        adv();
        trans_req_i    = 1'b0;
        data_req_i     = 1'b0;
        tcdm_r_valid_i = 1'b1;
        settle();
        checks++;
        if (synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_t1_synch got %b want 0", synch_req_o);
        end
        adv();
        tcdm_r_valid_i = 1'b0;
        settle();
        checks++;
        if (synch_req_o !== 1'b1 || synch_id_o !== 6'h15) begin
            errors++;
            $display("FAIL single_t2_synch got %b/%h want 1/15", synch_req_o, synch_id_o);
        end
        adv();
        settle();
        checks++;
        if (synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_t3_synch got %b want 0", synch_req_o);
        end
        adv();
        drain();
    endtask

    task automatic test_burst4();
        idle();
        tcdm_gnt_i  = 1'b1;
        synch_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_beat(6'h03, 32'h100 + 32'(4 * k), $urandom, 4'hF, k == 3);
            tcdm_r_valid_i = (k >= 1);
            settle();
            checks++;
            if (tcdm_req_o !== 1'b1 || trans_gnt_o !== 1'b1 || data_gnt_o !== 1'b1 || synch_req_o !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d got req %b tg %b dg %b sreq %b want 1 1 1 0", k, tcdm_req_o, trans_gnt_o, data_gnt_o, synch_req_o);
            end
            adv();
        end
        trans_req_i    = 1'b0;
        data_req_i     = 1'b0;
        tcdm_r_valid_i = 1'b1;
        settle();
        checks++;
        if (synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_early_synch got %b want 0", synch_req_o);
        end
        adv();
        tcdm_r_valid_i = 1'b0;
        settle();
        checks++;
        if (synch_req_o !== 1'b1 || synch_id_o !== 6'h03) begin
            errors++;
            $display("FAIL burst_synch got %b/%h want 1/03", synch_req_o, synch_id_o);
        end
        adv();
        settle();
        checks++;
        if (synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_single_synch got %b want 0", synch_req_o);
        end
        adv();
        drain();
    endtask

    task automatic test_gnt_stall();
        idle();
        drive_beat(6'h2A, 32'h200, 32'hA5A5_0001, 4'h3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (tcdm_req_o !== 1'b1 || trans_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || dut.cnt_out_q !== '0) begin
                errors++;
                $display("FAIL stall_cycle%0d got req %b tg %b dg %b cnt %0d want 1 0 0 0", k, tcdm_req_o, trans_gnt_o, data_gnt_o, dut.cnt_out_q);
            end
            adv();
        end
        tcdm_gnt_i = 1'b1;
        settle();
        checks++;
        if (trans_gnt_o !== 1'b1 || data_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept got tg %b dg %b want 1 1", trans_gnt_o, data_gnt_o);
        end
        adv();
        drain();
    endtask

    task automatic test_backpressure();
        idle();
        tcdm_gnt_i = 1'b1;
        for (int b = 1; b <= 2; b++) begin
            drive_beat(6'(b), 32'h300 + 32'(b * 4), $urandom, 4'hF, 1'b1);
            settle();
            adv();
            trans_req_i    = 1'b0;
            data_req_i     = 1'b0;
            tcdm_r_valid_i = 1'b1;
            settle();
            adv();
            tcdm_r_valid_i = 1'b0;
        end
        drive_beat(6'h07, 32'h340, 32'h0BAD_F00D, 4'h5, 1'b1);
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if (tcdm_req_o !== 1'b0 || dut.cnt_rsp_q !== 2'(DEPTH) || synch_id_o !== 6'd1) begin
                errors++;
                $display("FAIL bp_blocked got req %b cnt_rsp %0d sid %h want 0 2 01", tcdm_req_o, dut.cnt_rsp_q, synch_id_o);
            end
            adv();
        end
        synch_gnt_i = 1'b1;
        settle();
        checks++;
        if (synch_req_o !== 1'b1 || synch_id_o !== 6'd1 || tcdm_req_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_first got sreq %b sid %h req %b want 1 01 0", synch_req_o, synch_id_o, tcdm_req_o);
        end
        adv();
        settle();
        checks++;
        if (synch_req_o !== 1'b1 || synch_id_o !== 6'd2 || tcdm_req_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got sreq %b sid %h req %b want 1 02 1", synch_req_o, synch_id_o, tcdm_req_o);
        end
        adv();
        drain();
    endtask

    task automatic test_one_stream();
        for (int s = 0; s < 2; s++) begin
            idle();
            drive_beat(6'h09, 32'h400, 32'h5555_AAAA, 4'hC, 1'b1);
            if (s == 0) data_req_i = 1'b0;
            else        trans_req_i = 1'b0;
            tcdm_gnt_i  = 1'b1;
            synch_gnt_i = 1'b1;
            settle();
            checks++;
            if (tcdm_req_o !== 1'b0 || trans_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL one_stream%0d got req %b tg %b dg %b want 0 0 0", s, tcdm_req_o, trans_gnt_o, data_gnt_o);
            end
            adv();
            settle();
            checks++;
            if (dut.cnt_out_q !== '0 || synch_req_o !== 1'b0) begin
                errors++;
                $display("FAIL one_stream%0d_state got cnt %0d sreq %b want 0 0", s, dut.cnt_out_q, synch_req_o);
            end
            adv();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        tcdm_gnt_i = 1'b1;
        drive_beat(6'h05, 32'h500, 32'h1111_2222, 4'hF, 1'b0);
        settle();
        adv();
        rst_i = 1'b1;
        settle();
        checks++;
        if (tcdm_req_o !== 1'b0 || synch_req_o !== 1'b0 || trans_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got req %b sreq %b tg %b want 0 0 0", tcdm_req_o, synch_req_o, trans_gnt_o);
        end
        adv();
        rst_i          = 1'b0;
        trans_req_i    = 1'b0;
        data_req_i     = 1'b0;
        tcdm_r_valid_i = 1'b1;
        synch_gnt_i    = 1'b1;
        settle();
        checks++;
        if (dut.cnt_out_q !== '0 || synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_cleared got cnt_out %0d sreq %b want 0 0", dut.cnt_out_q, synch_req_o);
        end
        adv();
        tcdm_r_valid_i = 1'b0;
        drive_beat(6'h06, 32'h504, 32'h3333_4444, 4'hF, 1'b1);
        settle();
        checks++;
        if (dut.cnt_out_q !== '0 || dut.cnt_rsp_q !== '0 || synch_req_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stray got cnt %0d/%0d sreq %b want 0/0 0", dut.cnt_out_q, dut.cnt_rsp_q, synch_req_o);
        end
        checks++;
        if (tcdm_req_o !== 1'b1 || trans_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_next got req %b tg %b want 1 1", tcdm_req_o, trans_gnt_o);
        end
        adv();
        drain();
    endtask

    task automatic test_random();
        int         left;
        logic [5:0] bid;
        logic [31:0] addr;
        left = 0;
        bid  = '0;
        addr = '0;
        idle();
        for (int c = 0; c < 400; c++) begin
            if (!trans_req_i && !data_req_i) begin
                if (left == 0) begin
                    bid  = 6'($urandom);
                    left = $urandom_range(1, 4);
                    addr = $urandom & 32'hFFFF_FFFC;
                end
                trans_id_i   = bid;
                trans_add_i  = addr;
                trans_last_i = (left == 1);
                data_dat_i   = $urandom;
                data_strb_i  = 4'($urandom);
            end
            if (!trans_req_i) trans_req_i = ($urandom_range(0, 3) != 0);
            if (!data_req_i)  data_req_i  = ($urandom_range(0, 3) != 0);
            tcdm_gnt_i     = ($urandom_range(0, 3) != 0);
            synch_gnt_i    = ($urandom_range(0, 2) != 0);
            tcdm_r_valid_i = (out_q.size() != 0) && ($urandom_range(0, 2) != 0);
            tcdm_r_rdata_i = $urandom;
            settle();
            checks++;
            if (tcdm_req_o !== exp_req || trans_gnt_o !== exp_gnt || data_gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL rand_issue c%0d got req %b tg %b dg %b want %b %b %b", c, tcdm_req_o, trans_gnt_o, data_gnt_o, exp_req, exp_gnt, exp_gnt);
            end
            checks++;
            if (synch_req_o !== exp_sreq || synch_id_o !== exp_sid) begin
                errors++;
                $display("FAIL rand_synch c%0d got %b/%h want %b/%h", c, synch_req_o, synch_id_o, exp_sreq, exp_sid);
            end
            checks++;
            if (tcdm_add_o !== trans_add_i || tcdm_wdata_o !== data_dat_i || tcdm_be_o !== data_strb_i || tcdm_we_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_passthru c%0d got %h %h %h %b want %h %h %h 0", c, tcdm_add_o, tcdm_wdata_o, tcdm_be_o, tcdm_we_o, trans_add_i, data_dat_i, data_strb_i);
            end
            adv();
            if (last_issue) begin
                left        = left - 1;
                addr        = addr + 32'd4;
                trans_req_i = 1'b0;
                data_req_i  = 1'b0;
            end
        end
        settle();
        checks++;
        if (int'(dut.cnt_out_q) != out_q.size() || int'(dut.cnt_rsp_q) != rsp_q.size()) begin
            errors++;
            $display("FAIL rand_counts got %0d/%0d want %0d/%0d", dut.cnt_out_q, dut.cnt_rsp_q, out_q.size(), rsp_q.size());
        end
        adv();
        drain();
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_beat();
        test_burst4();
        test_gnt_stall();
        test_backpressure();
        test_one_stream();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
